// File: rtl/bsg_sha256_pkg.sv
// bsg_sha256_pkg
//   Shared types and default widths for the SHA-256 core arbiter.
//   sha_arb_state_e : arbiter FSM states (IDLE, ISSUE, BUSY, RESP)
//   *_default_gp    : default parameter values for the arbiter
//   sha_id_width()  : width of a requester index (at least 1 bit)
package bsg_sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } sha_arb_state_e;

    localparam int sha_num_req_default_gp    = 2;
    localparam int sha_msg_width_default_gp  = 512;
    localparam int sha_dig_width_default_gp  = 256;
    localparam int sha_timeout_default_gp    = 1024;

    function automatic int sha_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_sha256_rr_arb.sv
// bsg_sha256_rr_arb
//   Combinational round-robin picker. Searches upward from last_i+1 with
//   wrap and grants the first requester found.
//   req_i   : request vector
//   last_i  : index of the requester served last
//   grant_o : one-hot grant (all zero when no request)
//   id_o    : encoded index of the grant (0 when no request)
module bsg_sha256_rr_arb
    import bsg_sha256_pkg::*;
#(
    parameter int num_req_p = sha_num_req_default_gp,
    parameter int id_w_p    = sha_id_width(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [id_w_p-1:0]    last_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [id_w_p-1:0]    id_o
);

    // One spare bit so last_i + offset never overflows before the wrap.
    logic [id_w_p:0] cand;
    logic            found;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = {1'b0, last_i} + (id_w_p + 1)'(i);
            if (cand >= (id_w_p + 1)'(num_req_p))
                cand = cand - (id_w_p + 1)'(num_req_p);
            if (!found && req_i[cand[id_w_p-1:0]]) begin
                found                   = 1'b1;
                grant_o[cand[id_w_p-1:0]] = 1'b1;
                id_o                    = cand[id_w_p-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_sha256_arbiter.sv
// bsg_sha256_arbiter
//   Shares one SHA-256 core among num_req_p requesters, round-robin, one
//   message in flight at a time: accept -> issue to core -> capture digest
//   -> return digest to the granted requester.
//   clk_i, reset_i           : clock, synchronous active-high reset
//   req_v_i / req_msg_i      : per-requester message valid / messages
//   req_yumi_o               : one-hot acceptance pulse
//   resp_v_o / resp_digest_o : one-hot digest valid / shared digest
//   resp_yumi_i              : digest consumed (only id_r bit honoured)
//   core_v_o / core_msg_o    : message to core, core_ready_i accepts it
//   core_v_i / core_digest_i : digest from core, core_yumi_o takes it
//   err_o                    : sticky watchdog error
//   Build option BSG_SHA256_ARB_TIMEOUT_EN adds the BUSY watchdog
//   (timeout_p cycles); without it err_o is 0 and BUSY waits forever.
module bsg_sha256_arbiter
    import bsg_sha256_pkg::*;
#(
    parameter int num_req_p      = sha_num_req_default_gp,
    parameter int msg_width_p    = sha_msg_width_default_gp,
    parameter int digest_width_p = sha_dig_width_default_gp,
    parameter int timeout_p      = sha_timeout_default_gp
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*msg_width_p-1:0] req_msg_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic [num_req_p-1:0]             resp_v_o,
    output logic [digest_width_p-1:0]        resp_digest_o,
    input  logic [num_req_p-1:0]             resp_yumi_i,
    output logic                             core_v_o,
    output logic [msg_width_p-1:0]           core_msg_o,
    input  logic                             core_ready_i,
    input  logic                             core_v_i,
    input  logic [digest_width_p-1:0]        core_digest_i,
    output logic                             core_yumi_o,
    output logic                             err_o
);

    localparam int id_w_lp = sha_id_width(num_req_p);

    sha_arb_state_e                          state_r, state_n;
    logic [id_w_lp-1:0]                      last_r, id_r;
    logic [msg_width_p-1:0]                  msg_r;
    logic [digest_width_p-1:0]               digest_r;
    logic [num_req_p-1:0]                    pick_grant;
    logic [id_w_lp-1:0]                      pick_id;
    logic [num_req_p-1:0][msg_width_p-1:0]   req_msg_arr;
    logic                                    timeout;

    assign req_msg_arr = req_msg_i;

    bsg_sha256_rr_arb #(
        .num_req_p (num_req_p),
        .id_w_p    (id_w_lp)
    ) u_rr_arb (
        .req_i   (req_v_i),
        .last_i  (last_r),
        .grant_o (pick_grant),
        .id_o    (pick_id)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (|req_v_i)              state_n = ISSUE;
            ISSUE:   if (core_ready_i)          state_n = BUSY;
            BUSY:    if (core_v_i || timeout)   state_n = RESP;
            RESP:    if (resp_yumi_i[id_r])     state_n = IDLE;
            default:                            state_n = IDLE;
        endcase
    end

    // Outputs decoded from state (plus the two combinational handshakes)
    always_comb begin
        req_yumi_o  = (state_r == IDLE) ? pick_grant : '0;
        core_v_o    = (state_r == ISSUE);
        core_yumi_o = (state_r == BUSY) && core_v_i;
        resp_v_o    = '0;
        if (state_r == RESP) resp_v_o[id_r] = 1'b1;
    end

    assign core_msg_o    = msg_r;
    assign resp_digest_o = digest_r;

    // Transaction data; last_r resets to the top index so requester 0
    // wins the first arbitration.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r   <= id_w_lp'(num_req_p - 1);
            id_r     <= '0;
            msg_r    <= '0;
            digest_r <= '0;
        end else begin
            if (state_r == IDLE && |req_v_i) begin
                id_r  <= pick_id;
                msg_r <= req_msg_arr[pick_id];
            end
            if (state_r == BUSY) begin
                if (core_v_i)     digest_r <= core_digest_i;
                else if (timeout) digest_r <= '0;
            end
            if (state_r == RESP && resp_yumi_i[id_r])
                last_r <= id_r;
        end
    end

`ifdef BSG_SHA256_ARB_TIMEOUT_EN
    localparam int cnt_w_lp = $clog2(timeout_p + 1);

    logic [cnt_w_lp-1:0] cnt_r;
    logic                err_r;

    // cnt_r holds the number of BUSY cycles already spent; the cycle that
    // would make it timeout_p forces the move to RESP with a zero digest.
    assign timeout = (state_r == BUSY) && !core_v_i &&
                     (cnt_r == cnt_w_lp'(timeout_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (state_r == ISSUE)     cnt_r <= '0;
            else if (state_r == BUSY) cnt_r <= cnt_r + 1'b1;
            if (timeout)              err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    // No watchdog: BUSY waits for the core indefinitely.
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule

// File: doc/bsg_sha256_arbiter.md
# bsg_sha256_arbiter

Shares one SHA-256 core among `num_req_p` requesters with round-robin fairness. The arbiter sits between the requester ports and the core's message/digest handshakes. It accepts one message at a time, issues it to the core, captures the digest, and returns it to the granted requester. Only one message is in flight at a time; the core is never issued a second message before its digest is consumed.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters, 2..8.
- `msg_width_p`, 512: message block width.
- `digest_width_p`, 256: digest width.
- `timeout_p`, 1024: watchdog limit in cycles. Used only with `BSG_SHA256_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high.
- `req_v_i` in `num_req_p`: per-requester message valid.
- `req_msg_i` in `num_req_p*msg_width_p`: messages; requester k occupies slice k.
- `req_yumi_o` out `num_req_p`: one-hot, one-cycle acceptance pulse.
- `resp_v_o` out `num_req_p`: one-hot digest valid to the granted requester.
- `resp_digest_o` out `digest_width_p`: digest, shared by all requesters.
- `resp_yumi_i` in `num_req_p`: digest consumed.
- `core_v_o` out 1: message valid to core.
- `core_msg_o` out `msg_width_p`: message to core.
- `core_ready_i` in 1: core can accept a message.
- `core_v_i` in 1: core digest valid.
- `core_digest_i` in `digest_width_p`: core digest.
- `core_yumi_o` out 1: digest taken from core.
- `err_o` out 1: watchdog error, sticky.

## Operation
- Registered state: `state`, `last_r` (last served index), `id_r`, `msg_r`, `digest_r`.
- States:
  - IDLE: if any `req_v_i`, pick the first set bit searching upward from `last_r+1` with wrap. Pulse that `req_yumi_o` bit, latch `id_r` and `msg_r`, go to ISSUE.
  - ISSUE: `core_v_o`=1 with `core_msg_o`=`msg_r`. When `core_ready_i`, go to BUSY.
  - BUSY: `core_yumi_o`=`core_v_i`. When `core_v_i`, latch `digest_r` and go to RESP.
  - RESP: `resp_v_o[id_r]`=1 and `resp_digest_o`=`digest_r`. When `resp_yumi_i[id_r]`, set `last_r`=`id_r` and go to IDLE.
- `resp_yumi_i` bits other than `id_r` are ignored, as are `resp_yumi_i` bits outside RESP.
- `req_v_i` changes outside IDLE are ignored. Requesters hold `req_msg_i` stable while `req_v_i` is high and unacknowledged.
- A requester that holds `req_v_i` continuously is served again only after every other active requester has been served once.
- `core_v_i` asserted in IDLE, ISSUE or RESP: not consumed (`core_yumi_o`=0).

## Timing
- Reset values:
  - `state`=IDLE, `last_r`=`num_req_p-1` (requester 0 has first priority).
  - `req_yumi_o`, `resp_v_o`, `core_v_o`, `core_yumi_o` and `err_o` are all 0.
  - `resp_digest_o` and `core_msg_o` are 0.
- Reset mid-transaction: abandon at once and return to IDLE. In-flight data is dropped and the core is reset by the same `reset_i`.
- `req_yumi_o` is combinational from `req_v_i` in IDLE. `core_yumi_o` is combinational from `core_v_i` in BUSY. All other outputs are registered or decoded from state.
- Cycle-level latency:
  - Acceptance at cycle t gives `core_v_o` at t+1.
  - A core digest at cycle c gives `resp_v_o` at c+1.
  - `resp_yumi_i` at cycle r gives IDLE at r+1, so the next acceptance is at r+1 at the earliest.
- Minimum overhead is 3 arbiter cycles per message plus core latency.

## Configuration
Macro `BSG_SHA256_ARB_TIMEOUT_EN`:
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches `timeout_p`, `err_o` is set (sticky until reset).
  - The arbiter goes to RESP with `digest_r`=0, so the requester is not stalled.
- Undefined: no counter, `err_o` tied to 0, and BUSY waits indefinitely.

## Structure
- `bsg_sha256_pkg` holds:
  - the state enum `sha_arb_state_e` (IDLE, ISSUE, BUSY, RESP);
  - the default width constants.
- Sub-module `bsg_sha256_rr_arb`: a combinational round-robin picker.
  - Inputs: request vector and `last_r`.
  - Outputs: one-hot grant and encoded index.

## Test plan
- Single request: `req_v_i`=2'b01 with message M. Expect `req_yumi_o`=2'b01 at cycle 0 and `core_v_o` at cycle 1. Core returns D after 64 cycles; expect `resp_v_o`=2'b01 with D one cycle later.
- Contention: `req_v_i`=2'b11 held continuously. Expect the grant order 0,1,0,1 over four transactions and `resp_v_o` to be one-hot each time.
- Backpressure:
  - `core_ready_i` low for 5 cycles: `core_v_o` stays high with `core_msg_o` unchanged.
  - `resp_yumi_i` delayed 10 cycles: `resp_v_o` and the digest stay stable, and no new `req_yumi_o` is issued.
- Wrong consumer: in RESP with `id_r`=1, drive `resp_yumi_i`=2'b01. Expect the arbiter to stay in RESP.
- Reset mid-BUSY: assert `reset_i` for 1 cycle. Expect all outputs 0 next cycle, and requester 0 to win the next contention.
- Timeout (macro defined, `timeout_p`=16): core never responds. Expect `err_o`=1 and `resp_v_o` with digest 0 exactly 16 BUSY cycles after issue.
